// File: rtl/gpio_pkg.sv
// Shared constants for the AHB-Lite GPIO port: register offsets (word index
// from HADDR[4:2]) and the AHB transfer-type encoding.
package gpio_pkg;
    typedef logic [2:0] gpio_off_t;

    localparam gpio_off_t GPIO_DATAIN  = 3'd0;
    localparam gpio_off_t GPIO_DATAOUT = 3'd1;
    localparam gpio_off_t GPIO_DIR     = 3'd2;
    localparam gpio_off_t GPIO_IE      = 3'd3;
    localparam gpio_off_t GPIO_EDGE    = 3'd4;
    localparam gpio_off_t GPIO_STATUS  = 3'd5;

    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
endpackage

// File: rtl/gpio_sync_edge.sv
// Pad-input synchroniser followed by one extra flop, so that rising and
// falling edges can be detected on the synchronised value.
module gpio_sync_edge
    import gpio_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-1:0] sync_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o
);
    logic [SYNC_STAGES-1:0][WIDTH-1:0] chain_q;
    logic [WIDTH-1:0]                  sync_dly_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            chain_q    <= '0;
            sync_dly_q <= '0;
        end else begin
            chain_q    <= {chain_q[SYNC_STAGES-2:0], async_i};
            sync_dly_q <= chain_q[SYNC_STAGES-1];
        end
    end

    assign sync_o = chain_q[SYNC_STAGES-1];
    assign rise_o = sync_o & ~sync_dly_q;
    assign fall_o = ~sync_o & sync_dly_q;
endmodule

// File: rtl/ahbl_gpio_port.sv
// Zero-wait-state AHB-Lite slave for one GPIO port: data-out, direction,
// synchronised data-in and sticky per-pin edge interrupts.
module ahbl_gpio_port
    import gpio_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             HCLK,
    input  logic             HRESET,
    input  logic             HSEL,
    input  logic [31:0]      HADDR,
    input  logic [1:0]       HTRANS,
    input  logic             HWRITE,
    input  logic [31:0]      HWDATA,
    input  logic             HREADY,
    output logic             HREADYOUT,
    output logic [31:0]      HRDATA,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq
);
    gpio_off_t        addr_q;
    logic             wr_q, act_q, irq_q;
    logic [WIDTH-1:0] dout_q, dout_d, dir_q, dir_d, ie_q, ie_d;
    logic [WIDTH-1:0] esel_q, esel_d, status_q, status_d;
    logic [WIDTH-1:0] sync, rise, fall, ev, w1c;
    logic             valid, wr_en;
    logic             unused_ok;

    assign unused_ok = ^{HADDR[31:5], HADDR[1:0], HTRANS[0], HWDATA};

    gpio_sync_edge #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk_i  (HCLK),
        .rst_i  (HRESET),
        .async_i(gpio_in),
        .sync_o (sync),
        .rise_o (rise),
        .fall_o (fall)
    );

    assign valid = HSEL & HTRANS[1] & HREADY;
    assign wr_en = act_q & wr_q;
    assign ev    = (esel_q & rise) | (~esel_q & fall);

    always_comb begin
        dout_d = dout_q;
        dir_d  = dir_q;
        ie_d   = ie_q;
        esel_d = esel_q;
        w1c    = '0;
        if (wr_en) begin
            case (addr_q)
                GPIO_DATAOUT: dout_d = HWDATA[WIDTH-1:0];
                GPIO_DIR:     dir_d  = HWDATA[WIDTH-1:0];
                GPIO_IE:      ie_d   = HWDATA[WIDTH-1:0];
                GPIO_EDGE:    esel_d = HWDATA[WIDTH-1:0];
                GPIO_STATUS:  w1c    = HWDATA[WIDTH-1:0];
                default: ;
            endcase
        end
        // An edge arriving in the same cycle as its W1C must not be lost.
        status_d = (status_q & ~w1c) | ev;
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            addr_q   <= '0;
            wr_q     <= 1'b0;
            act_q    <= 1'b0;
            dout_q   <= '0;
            dir_q    <= '0;
            ie_q     <= '0;
            esel_q   <= '0;
            status_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            act_q    <= valid;
            if (valid) begin
                addr_q <= HADDR[4:2];
                wr_q   <= HWRITE;
            end
            dout_q   <= dout_d;
            dir_q    <= dir_d;
            ie_q     <= ie_d;
            esel_q   <= esel_d;
            status_q <= status_d;
            irq_q    <= |(status_d & ie_q);
        end
    end

    always_comb begin
        HRDATA = '0;
        if (act_q & ~wr_q) begin
            case (addr_q)
                GPIO_DATAIN:  HRDATA[WIDTH-1:0] = sync;
                GPIO_DATAOUT: HRDATA[WIDTH-1:0] = dout_q;
                GPIO_DIR:     HRDATA[WIDTH-1:0] = dir_q;
                GPIO_IE:      HRDATA[WIDTH-1:0] = ie_q;
                GPIO_EDGE:    HRDATA[WIDTH-1:0] = esel_q;
                GPIO_STATUS:  HRDATA[WIDTH-1:0] = status_q;
                default: ;
            endcase
        end
    end

    assign HREADYOUT = 1'b1;
    assign gpio_out  = dout_q;
    assign gpio_oe   = dir_q;
    assign irq       = irq_q;
endmodule

// File: tb/tb_ahbl_gpio_port.sv
// Directed bench for ahbl_gpio_port (WIDTH=16, SYNC_STAGES=2) with
// hand-computed expectations.
module tb_ahbl_gpio_port;
    logic        HCLK, HRESET, HSEL, HWRITE, HREADY, HREADYOUT, irq;
    logic [31:0] HADDR, HWDATA, HRDATA, d;
    logic [1:0]  HTRANS;
    logic [15:0] gpio_in, gpio_out, gpio_oe;
    int vectors = 0;
    int miscompares = 0;

    ahbl_gpio_port #(.WIDTH(16), .SYNC_STAGES(2)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR),
        .HTRANS(HTRANS), .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY),
        .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .gpio_in(gpio_in),
        .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic addr(input logic [31:0] a, input logic w);
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = a; HWRITE = w;
    endtask

    task automatic idle();
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] v);
        addr(a, 1'b1); tick();
        idle(); HWDATA = v; tick();
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] v);
        addr(a, 1'b0); tick();
        idle(); v = HRDATA; tick();
    endtask

    initial begin
        HRESET = 1'b1; HSEL = 1'b0; HADDR = '0; HTRANS = 2'b00; HWRITE = 1'b0;
        HWDATA = '0; HREADY = 1'b1; gpio_in = '0;
        repeat (3) @(posedge HCLK);
        #1 HRESET = 1'b0;

        // Reset state and every offset reads zero
        chk("rst_gpio_out", {16'h0, gpio_out}, 32'h0);
        chk("rst_gpio_oe", {16'h0, gpio_oe}, 32'h0);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        chk("rst_hrdata", HRDATA, 32'h0);
        for (int i = 0; i < 8; i++) begin
            rd(i * 4, d);
            chk($sformatf("rst_rd_%0h", i * 4), d, 32'h0);
            chk("hreadyout", {31'h0, HREADYOUT}, 32'h1);
        end

        // Pipelined: write DATAOUT, write DIR, read DIR, read DATAOUT
        addr(32'h04, 1'b1); tick();
        HWDATA = 32'hA5A5; addr(32'h08, 1'b1); tick();
        chk("dout_after_wr", {16'h0, gpio_out}, 32'hA5A5);
        chk("oe_before_wr", {16'h0, gpio_oe}, 32'h0);
        HWDATA = 32'h00FF; addr(32'h08, 1'b0); tick();
        chk("oe_after_wr", {16'h0, gpio_oe}, 32'h00FF);
        addr(32'h04, 1'b0);
        chk("rd_dir_b2b", HRDATA, 32'h00FF);
        tick();
        idle();
        chk("rd_dout_b2b", HRDATA, 32'hA5A5);
        tick();
        wr(32'h04, 32'hFFFF_FFFF);
        rd(32'h04, d);
        chk("dout_width_mask", d, 32'h0000_FFFF);

        // Synchroniser latency and read-only DATAIN
        gpio_in = 16'h0003; tick(); tick();
        addr(32'h00, 1'b0); tick();
        chk("datain_latency", HRDATA, 32'h3);
        idle(); tick();
        wr(32'h00, 32'h1234);
        rd(32'h00, d);
        chk("datain_ro", d, 32'h3);

        // Edge interrupts: EDGE=1 / IE=1 on bit 0, bit 1 stays falling-edge
        wr(32'h10, 32'h1);
        wr(32'h0C, 32'h1);
        gpio_in = 16'h0000; repeat (4) tick();
        chk("irq_masked", {31'h0, irq}, 32'h0);
        rd(32'h14, d);
        chk("status_fall_b1", d, 32'h2);
        wr(32'h14, 32'hFFFF);
        rd(32'h14, d);
        chk("status_cleared", d, 32'h0);
        gpio_in = 16'h0001; repeat (4) tick();
        chk("irq_rise", {31'h0, irq}, 32'h1);
        rd(32'h14, d);
        chk("status_rise", d, 32'h1);
        wr(32'h14, 32'h1);
        chk("irq_after_w1c", {31'h0, irq}, 32'h0);
        rd(32'h14, d);
        chk("status_after_w1c", d, 32'h0);
        gpio_in = 16'h0000; repeat (4) tick();
        rd(32'h14, d);
        chk("no_set_on_fall", d, 32'h0);
        chk("irq_no_fall", {31'h0, irq}, 32'h0);

        // Set wins over same-cycle W1C: sync rises 2 edges after the pin,
        // which lands in the data phase of the W1C write below.
        gpio_in = 16'h0001; repeat (4) tick();
        gpio_in = 16'h0000; repeat (4) tick();
        rd(32'h14, d);
        chk("status_pre_collide", d, 32'h1);
        gpio_in = 16'h0001; tick();
        wr(32'h14, 32'h1);
        chk("irq_collide", {31'h0, irq}, 32'h1);
        rd(32'h14, d);
        chk("status_set_wins", d, 32'h1);

        // Reset during a write data phase drops the write
        wr(32'h04, 32'h00F0);
        chk("dout_pre_rst", {16'h0, gpio_out}, 32'h00F0);
        addr(32'h04, 1'b1); tick();
        idle(); HWDATA = 32'hFFFF;
        #2 HRESET = 1'b1;
        #1 chk("dout_async_rst", {16'h0, gpio_out}, 32'h0);
        @(posedge HCLK); #1 HRESET = 1'b0;
        tick();
        chk("dout_post_rst", {16'h0, gpio_out}, 32'h0);
        rd(32'h04, d);
        chk("rd_dout_post_rst", d, 32'h0);
        chk("irq_post_rst", {31'h0, irq}, 32'h0);

        // HSEL with IDLE transfer, then valid NONSEQ with HREADY low
        HSEL = 1'b1; HTRANS = 2'b00; HADDR = 32'h04; HWRITE = 1'b1; tick();
        idle(); HWDATA = 32'h5555; tick();
        rd(32'h04, d);
        chk("idle_no_write", d, 32'h0);
        addr(32'h04, 1'b1); HREADY = 1'b0; tick();
        idle(); HREADY = 1'b1; HWDATA = 32'h5555; tick();
        rd(32'h04, d);
        chk("hready_low_no_write", d, 32'h0);
        chk("gpio_out_final", {16'h0, gpio_out}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
